wr_ddr_burst_master: RTL and testbench
======================================

// Module: wr_ddr_burst_master
// PURPOSE
//  Write-direction DDR burst master. Pops beats from a prefetch FIFO's valid/ready read port.
//  Issues fixed-length AXI4 INCR write bursts (AW + W channels) to the DDR controller.
//  Counterpart of the read-side DDR FIFO path. Runs in the DDR user clock domain.
// PARAMETERS
//  ADDR_W     28   byte address width of m_awaddr / frame_base
//  DATA_W     256  FIFO and W-channel data width; power of 2, >= 8
//  LEVEL_W    10   width of fifo_level (FIFO read-side water level)
//  BURST_LEN  16   beats per burst, 1..256; m_awlen = BURST_LEN-1
//  CNT_W      16   width of frame_bursts
// PORTS
//  clk           in   1        single clock
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle pulse: begin frame; ignored while busy=1
//  frame_base    in   ADDR_W   first burst byte address, sampled on accepted start
//  frame_bursts  in   CNT_W    bursts per frame, sampled on accepted start
//  busy          out  1        high from accepted start to done
//  done          out  1        1-cycle pulse when the frame's last burst completes
//  err           out  1        sticky write-response error (macro only, else 0)
//  fifo_data     in   DATA_W   FIFO head data
//  fifo_vld      in   1        FIFO head valid
//  fifo_rd_en    out  1        FIFO ready/pop; pop = fifo_vld & fifo_rd_en
//  fifo_level    in   LEVEL_W  FIFO occupancy in beats
//  m_awaddr      out  ADDR_W   AXI write address
//  m_awlen       out  8        constant BURST_LEN-1
//  m_awvalid     out  1        AXI AW valid
//  m_awready     in   1        AXI AW ready
//  m_wdata       out  DATA_W   = fifo_data
//  m_wstrb       out  DATA_W/8 all ones
//  m_wlast       out  1        last beat of the burst
//  m_wvalid      out  1        AXI W valid
//  m_wready      in   1        AXI W ready
//  m_bresp       in   2        AXI write response
//  m_bvalid      in   1        AXI B valid
//  m_bready      out  1        AXI B ready
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, err, m_awvalid, m_wvalid, m_wlast and fifo_rd_en = 0.
//   Address and beat/burst counters = 0. m_bready = 1 without the macro, 0 with it.
//  FSM: IDLE, WAIT_DATA, AW, W, B (B exists only with the macro).
//  IDLE: start -> latch base and count, busy=1.
//   If frame_bursts==0: done pulses next cycle, stay IDLE.
//   Otherwise go to WAIT_DATA.
//  WAIT_DATA: when fifo_level >= BURST_LEN -> AW.
//   This guarantees a burst never stalls mid-way on FIFO underflow.
//  AW: m_awvalid=1 with stable m_awaddr until m_awready; then -> W (registered, 1-cycle transition).
//  W: m_wvalid = fifo_vld; fifo_rd_en = m_wready; m_wdata = fifo_data.
//   These paths are combinational: 0-cycle latency, no extra buffering.
//   Beat counter advances on fifo_vld & m_wready.
//   m_wlast = (beat_cnt == BURST_LEN-1) & m_wvalid.
//   On the last beat accepted: addr += BURST_LEN*DATA_W/8 (wraps mod 2^ADDR_W), remaining -= 1.
//   Then -> B (macro), or -> next state per the rule below.
//  Next state: if remaining==0 -> done=1 for 1 cycle, busy=0, IDLE; else -> WAIT_DATA.
//  fifo_rd_en is 0 in every state other than W. No pops occur outside W.
//  start while busy is ignored; frame_base and frame_bursts changes while busy have no effect.
//  A done and a new start in the same cycle: start is ignored (busy still 1).
//  Reset mid-burst: immediate return to reset values. The partially written burst is abandoned.
// CONFIGURATION
//  WR_DDR_BRESP_CHECK_EN defined:
//   After each W burst, enter B. m_bready=1 only in B.
//   On m_bvalid, leave B per the next-state rule.
//   m_bresp != 2'b00 sets err; err stays set until the next accepted start.
//  Undefined: no B state; m_bready tied 1; err tied 0; the response is ignored.
// TESTING
//  T1 reset: rst_n=0 with random inputs -> all outputs at reset values; fifo_rd_en=0.
//  T2 single frame: base=0x100, bursts=2, DATA_W=256, BURST_LEN=16, FIFO preloaded with 32 beats.
//   Expect AW addrs 0x100 then 0x300, each awlen=15.
//   Expect 32 beats in FIFO order, wlast on beats 16 and 32, one done pulse, busy low after.
//  T3 backpressure: random m_wready and m_awready at 50%.
//   Data order intact, no pop unless fifo_vld & m_wready, awaddr stable while awvalid & !awready.
//  T4 underflow guard: fifo_level=15 held -> stays in WAIT_DATA, no awvalid.
//   Raise level to 16 -> awvalid next cycle.
//  T5 edges: bursts=0 -> done 1 cycle after start.
//   base = 2^ADDR_W-512, bursts=2 -> second awaddr=0 (wrap).
//   Start while busy -> ignored.
//  T6 macro on: bresp=2'b10 on burst 1 -> err=1, sticky through the frame, cleared by the next start.
//   Next AW waits for bvalid.

Source files
------------

// File: rtl/wr_ddr_burst_master.sv
// wr_ddr_burst_master: write-direction DDR burst master.
// Pops beats from a prefetch FIFO (valid/ready read port) and issues fixed-length
// AXI4 INCR write bursts on the AW and W channels, one frame of bursts per start.
// Optional feature macro: WR_DDR_BRESP_CHECK_EN adds a B state that waits for each
// write response and records a sticky error on a non-OKAY response.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no burst in flight; accepts start when not busy
// WAIT_DATA | waits for a full burst of beats in the FIFO before AW
// AW        | m_awvalid held with stable m_awaddr until m_awready
// W         | FIFO head forwarded combinationally to the W channel
// B         | (macro only) m_bready high, waits for the write response
module wr_ddr_burst_master #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 256,
    parameter int LEVEL_W   = 10,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   frame_base,
    input  logic [CNT_W-1:0]    frame_bursts,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic [DATA_W-1:0]   fifo_data,
    input  logic                fifo_vld,
    output logic                fifo_rd_en,
    input  logic [LEVEL_W-1:0]  fifo_level,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * (DATA_W / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_AW,
        S_W
`ifdef WR_DDR_BRESP_CHECK_EN
        , S_B
`endif
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   remaining;
    logic [7:0]         beat_cnt;
    logic               start_acc;
    logic               beat_acc;
    logic               last_acc;
    logic               frame_end;

    // A start arriving during the done cycle is dropped because busy is still high.
    assign start_acc = start & ~busy;

    assign m_awaddr = addr_q;
    assign m_awlen  = LAST_BEAT;
    assign m_wdata  = fifo_data;
    assign m_wstrb  = '1;
    assign m_wlast  = (beat_cnt == LAST_BEAT) & m_wvalid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and channel handshake outputs.
    always_comb begin
        state_d    = state_q;
        frame_end  = 1'b0;
        beat_acc   = 1'b0;
        last_acc   = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        fifo_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_acc && frame_bursts != '0) state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                // Only enter AW once the whole burst is buffered, so W never underflows.
                if (32'(fifo_level) >= 32'(BURST_LEN)) state_d = S_AW;
            end
            S_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) state_d = S_W;
            end
            S_W: begin
                m_wvalid   = fifo_vld;
                fifo_rd_en = m_wready;
                beat_acc   = fifo_vld & m_wready;
                last_acc   = beat_acc & (beat_cnt == LAST_BEAT);
                if (last_acc) begin
`ifdef WR_DDR_BRESP_CHECK_EN
                    state_d = S_B;
`else
                    if (remaining == CNT_W'(1)) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_WAIT_DATA;
                    end
`endif
                end
            end
`ifdef WR_DDR_BRESP_CHECK_EN
            S_B: begin
                // remaining was already decremented on the last W beat.
                if (m_bvalid) begin
                    if (remaining == '0) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_WAIT_DATA;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Frame bookkeeping: address, burst and beat counters, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= frame_end;
            if (start_acc) begin
                addr_q    <= frame_base;
                remaining <= frame_bursts;
                beat_cnt  <= '0;
                busy      <= 1'b1;
                done      <= (frame_bursts == '0);
            end else if (done) begin
                busy <= 1'b0;
            end
            if (beat_acc) begin
                if (last_acc) begin
                    beat_cnt  <= '0;
                    addr_q    <= addr_q + ADDR_STEP;
                    remaining <= remaining - CNT_W'(1);
                end else begin
                    beat_cnt  <= beat_cnt + 8'd1;
                end
            end
        end
    end

`ifdef WR_DDR_BRESP_CHECK_EN
    assign m_bready = (state_q == S_B);

    // Sticky response error, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         err <= 1'b0;
        else if (start_acc)                                 err <= 1'b0;
        else if (state_q == S_B && m_bvalid && m_bresp != 2'b00) err <= 1'b1;
    end
`else
    assign m_bready = 1'b1;
    assign err      = 1'b0;
    wire unused_bresp = ^{m_bresp, m_bvalid};
`endif

endmodule

// File: tb/tb_wr_ddr_burst_master.sv
// Bench for wr_ddr_burst_master: FIFO and AXI slave models driven from $urandom,
// expected AW addresses and W beats computed from base + i*burst_bytes and FIFO order.
module tb_wr_ddr_burst_master;

    localparam int ADDR_W = 28, DATA_W = 256, LEVEL_W = 10, BLEN = 16, CNT_W = 16;
    localparam int BBYTES = BLEN * DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   frame_base;
    logic [CNT_W-1:0]    frame_bursts;
    logic                busy, done, err;
    logic [DATA_W-1:0]   fifo_data;
    logic                fifo_vld;
    logic                fifo_rd_en;
    logic [LEVEL_W-1:0]  fifo_level;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic                m_awvalid, m_awready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast, m_wvalid, m_wready;
    logic [1:0]          m_bresp;
    logic                m_bvalid, m_bready;

    wr_ddr_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .BURST_LEN(BLEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
        .frame_bursts(frame_bursts), .busy(busy), .done(done), .err(err),
        .fifo_data(fifo_data), .fifo_vld(fifo_vld), .fifo_rd_en(fifo_rd_en),
        .fifo_level(fifo_level), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_d[$];
    logic [ADDR_W-1:0] exp_aw[$];
    int checks = 0, errors = 0;
    int beat_idx = 0, done_cnt = 0;
    int aw_rate = 100, w_rate = 100, vld_rate = 100;
    int level_ovr = -1;
    bit start_req = 0;
    logic [ADDR_W-1:0] base_req = '0;
    logic [CNT_W-1:0]  bursts_req = '0;
    bit prev_aw_stall = 0, prev_done = 0;
    logic [ADDR_W-1:0] prev_awaddr = '0;
    int bpend = 0, b_idx = 0, berr_at = -1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd256();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive inputs after negedge, observe at negedge+1, update models at posedge.
    task automatic tick();
        bit pop, whs, last_model, bhs;
        @(negedge clk);
        start        = start_req;
        frame_base   = start_req ? base_req : ADDR_W'($urandom);
        frame_bursts = start_req ? bursts_req : CNT_W'($urandom);
        start_req    = 0;
        m_awready = ($urandom_range(0, 99) < aw_rate);
        m_wready  = ($urandom_range(0, 99) < w_rate);
        fifo_vld  = (fq.size() > 0) && ($urandom_range(0, 99) < vld_rate);
        fifo_data = (fq.size() > 0) ? fq[0] : rnd256();
        fifo_level = (level_ovr >= 0) ? LEVEL_W'(level_ovr) : LEVEL_W'(fq.size());
`ifdef WR_DDR_BRESP_CHECK_EN
        m_bvalid = (bpend > 0) && ($urandom_range(0, 1) == 1);
        m_bresp  = (b_idx == berr_at) ? 2'b10 : 2'b00;
`else
        m_bvalid = 1'($urandom);
        m_bresp  = 2'($urandom);
`endif
        #1;
        chk("pop_vs_w_handshake", fifo_vld & fifo_rd_en, m_wvalid & m_wready);
        if (fifo_rd_en) chk("rd_en_needs_wready", m_wready, 1'b1);
        if (prev_aw_stall) begin
            chk("aw_hold_valid", m_awvalid, 1'b1);
            chk("aw_hold_addr", m_awaddr, prev_awaddr);
        end
        if (m_awvalid && m_awready) begin
            if (exp_aw.size() > 0) chk("awaddr", m_awaddr, exp_aw.pop_front());
            else chk("aw_extra", exp_aw.size(), 1);
            chk("awlen", m_awlen, BLEN - 1);
        end
        last_model = ((beat_idx % BLEN) == BLEN - 1);
        if (m_wvalid) begin
            chk("wlast", m_wlast, last_model);
            chk("wstrb", m_wstrb, {(DATA_W/8){1'b1}});
        end
        whs = m_wvalid & m_wready;
        if (whs) begin
            if (exp_d.size() > 0) chk("wdata", m_wdata, exp_d.pop_front());
            else chk("w_extra", exp_d.size(), 1);
            beat_idx++;
        end
        if (prev_done) chk("done_one_cycle", done, 1'b0);
        if (done) done_cnt++;
`ifdef WR_DDR_BRESP_CHECK_EN
        if (bpend > 0) chk("aw_waits_for_b", m_awvalid, 1'b0);
        chk("bready_only_in_b", m_bready, bpend > 0);
        bhs = m_bvalid & m_bready;
`else
        chk("err_tied_low", err, 1'b0);
        chk("bready_tied_high", m_bready, 1'b1);
        bhs = 0;
`endif
        prev_aw_stall = m_awvalid & ~m_awready;
        prev_awaddr   = m_awaddr;
        prev_done     = done;
        pop           = fifo_vld & fifo_rd_en;
        @(posedge clk);
        if (pop && fq.size() > 0) void'(fq.pop_front());
        if (whs && last_model) bpend++;
        if (bhs) begin bpend--; b_idx++; end
    endtask

    task automatic setup(input logic [ADDR_W-1:0] base, input int nb);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < nb; i++) exp_aw.push_back(ADDR_W'(64'(base) + 64'(i) * BBYTES));
        for (int i = 0; i < nb * BLEN; i++) begin
            d = rnd256();
            fq.push_back(d);
            exp_d.push_back(d);
        end
        done_cnt = 0; beat_idx = 0; b_idx = 0;
        base_req = base; bursts_req = CNT_W'(nb); start_req = 1;
        tick();
        tick();
        chk("busy_after_start", busy, 1'b1);
`ifdef WR_DDR_BRESP_CHECK_EN
        chk("err_clear_on_start", err, 1'b0);
`endif
    endtask

    task automatic wait_done(input int budget, input bit inject);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (inject && n == 20) begin
                start_req = 1; base_req = ADDR_W'($urandom); bursts_req = 5;
            end
            tick();
            n++;
        end
        chk("frame_timeout", n < budget, 1'b1);
        tick();
        chk("busy_after_done", busy, 1'b0);
        chk("done_count", done_cnt, 1);
        chk("aw_left", exp_aw.size(), 0);
        chk("w_left", exp_d.size(), 0);
        chk("fifo_left", fq.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_awvalid"}, m_awvalid, 1'b0);
        chk({tag, "_wvalid"}, m_wvalid, 1'b0);
        chk({tag, "_wlast"}, m_wlast, 1'b0);
        chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        chk({tag, "_awaddr"}, m_awaddr, 0);
`ifdef WR_DDR_BRESP_CHECK_EN
        chk({tag, "_bready"}, m_bready, 1'b0);
`else
        chk({tag, "_bready"}, m_bready, 1'b1);
`endif
    endtask

    initial begin
        // T1: reset with random inputs
        rst_n = 0;
        start = 1; frame_base = ADDR_W'($urandom); frame_bursts = CNT_W'($urandom);
        fifo_data = rnd256(); fifo_vld = 1; fifo_level = LEVEL_W'($urandom);
        m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b10;
        #3;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        start = 0;

        // T2: single frame, base 0x100, two bursts, no backpressure
        setup(28'h100, 2);
        wait_done(500, 0);

        // T3: 50% backpressure on AW and W, FIFO valid gaps, start while busy ignored
        aw_rate = 50; w_rate = 50; vld_rate = 80;
        setup(ADDR_W'($urandom), 6);
        wait_done(3000, 1);
        setup(ADDR_W'($urandom), $urandom_range(1, 4));
        wait_done(3000, 0);
        aw_rate = 100; w_rate = 100; vld_rate = 100;

        // T4: level one short of a burst holds the master in WAIT_DATA
        level_ovr = 15;
        setup(28'h4000, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("underflow_guard_no_aw", m_awvalid, 1'b0);
        end
        level_ovr = 16;
        tick();
        tick();
        chk("aw_after_level_ok", m_awvalid, 1'b1);
        level_ovr = -1;
        wait_done(500, 0);

        // T5: zero-burst frame, start in the done cycle, address wrap
        base_req = 28'h123; bursts_req = 0; start_req = 1;
        tick();
        base_req = 28'h0; bursts_req = 1; start_req = 1;
        tick();
        chk("zero_frame_done", done, 1'b1);
        chk("zero_frame_busy", busy, 1'b1);
        tick();
        chk("zero_frame_busy_clr", busy, 1'b0);
        chk("zero_frame_done_clr", done, 1'b0);
        repeat (4) tick();
        chk("start_in_done_cycle_ignored", busy, 1'b0);
        setup(ADDR_W'((64'd1 << ADDR_W) - 512), 2);
        wait_done(500, 0);

        // Reset in the middle of a burst abandons it
        setup(28'h800, 3);
        repeat (8) tick();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk_reset_outputs("midburst_reset");
        @(negedge clk);
        rst_n = 1;
        fq.delete(); exp_aw.delete(); exp_d.delete();
        prev_aw_stall = 0; prev_done = 0; bpend = 0;
        setup(28'h2000, 1);
        wait_done(500, 0);

`ifdef WR_DDR_BRESP_CHECK_EN
        // T6: error response on the first burst is sticky until the next start
        berr_at = 0;
        setup(28'h10000, 3);
        wait_done(2000, 0);
        chk("err_sticky_after_frame", err, 1'b1);
        berr_at = -1;
        setup(28'h20000, 1);
        wait_done(500, 0);
        chk("err_stays_clear", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
